// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing constants, raster total derivation and colour expansion
package vga_pkg;
  localparam int DEF_DIV = 4;
  localparam int DEF_H_ACTIVE = 640, DEF_H_FP = 16, DEF_H_SYNC = 96, DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480, DEF_V_FP = 10, DEF_V_SYNC = 2, DEF_V_BP = 33;
  function automatic int span(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
  function automatic logic [15:0] ch_expand(input logic b, input int unsigned w);
    return b ? ~(16'hffff << w) : 16'h0000;
  endfunction
endpackage

// File: rtl/vga_paint_core_if.sv
// vga_paint_core_if: cursor inputs and pixel outputs between the input logic and the VGA pins
interface vga_paint_core_if #(
  parameter int POS_W = 10,
  parameter int CH_W = 3,
  parameter int SIZE_W = 2
);
  logic [POS_W-1:0] x_pos, y_pos, hcount, vcount;
  logic [2:0] color;
  logic tool_on, hsync, vsync, active, frame_start;
  logic [SIZE_W-1:0] size_sel;
  logic [CH_W-1:0] red, green, blue;
  modport master(
    output x_pos, y_pos, color, tool_on, size_sel,
    input red, green, blue, hsync, vsync, active, hcount, vcount, frame_start
  );
  modport slave(
    input x_pos, y_pos, color, tool_on, size_sel,
    output red, green, blue, hsync, vsync, active, hcount, vcount, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: pixel enable divider, h/v raster counters, raw sync/active and frame boundary strobe
module vga_timing
  import vga_pkg::*;
#(
  parameter int DIV = DEF_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE, H_FP = DEF_H_FP, H_SYNC = DEF_H_SYNC, H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE, V_FP = DEF_V_FP, V_SYNC = DEF_V_SYNC, V_BP = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int POS_W = 10
) (
  input  logic clk,
  input  logic clr,
  output logic pix_ce,
  output logic [POS_W-1:0] h,
  output logic [POS_W-1:0] v,
  output logic hs,
  output logic vs,
  output logic act,
  output logic bnd
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int H_TOTAL = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1), V_LAST = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] HA = POS_W'(H_ACTIVE), VA = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS0 = POS_W'(H_ACTIVE + H_FP), HS1 = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS0 = POS_W'(V_ACTIVE + V_FP), VS1 = POS_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div_cnt;
  always_comb begin
    pix_ce = div_cnt == DW'(DIV - 1);
    bnd = pix_ce && h == H_LAST && v == V_LAST;
    act = h < HA && v < VA;
    hs = (h >= HS0 && h < HS1) ? SYNC_POL : ~SYNC_POL;
    vs = (v >= VS0 && v < VS1) ? SYNC_POL : ~SYNC_POL;
  end
  always_ff @(posedge clk)
    if (clr) begin
      div_cnt <= '0;
      h <= '0;
      v <= '0;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
      if (pix_ce) begin
        h <= h == H_LAST ? '0 : h + 1'b1;
        if (h == H_LAST) v <= v == V_LAST ? '0 : v + 1'b1;
      end
    end
endmodule

// File: rtl/vga_paint_core.sv
// vga_paint_core: VGA raster with a brush cursor whose state is latched once per frame
module vga_paint_core
  import vga_pkg::*;
#(
  parameter int DIV = DEF_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE, H_FP = DEF_H_FP, H_SYNC = DEF_H_SYNC, H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE, V_FP = DEF_V_FP, V_SYNC = DEF_V_SYNC, V_BP = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int POS_W = 10,
  parameter int CH_W = 3,
  parameter int SIZE_W = 2,
  parameter int BASE_R = 2,
  parameter int BLINK_FRAMES = 30,
  parameter logic [2:0] BG = 3'b000
) (
  input logic clk,
  input logic clr,
  vga_paint_core_if.slave bus
);
  localparam int RW = POS_W + SIZE_W;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic pix_ce, bnd, hs, vs, act, ts, blink, in_brush, on_rim;
  logic [POS_W-1:0] h, v, xs, ys;
  logic [2:0] cs, pc;
  logic [SIZE_W-1:0] ss;
  logic [BW-1:0] bcnt;
  logic [RW-1:0] r, dx, dy;
  vga_timing #(
    .DIV(DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .POS_W(POS_W)
  ) u_timing (
    .clk(clk), .clr(clr), .pix_ce(pix_ce), .h(h), .v(v),
    .hs(hs), .vs(vs), .act(act), .bnd(bnd)
  );
  // Unsigned distance, no edge wrap: a cursor near column 0 is clipped, never mirrored
  always_comb begin
    r = RW'(BASE_R) << ss;
    dx = RW'(h > xs ? h - xs : xs - h);
    dy = RW'(v > ys ? v - ys : ys - v);
    in_brush = dx <= r && dy <= r;
    on_rim = in_brush && (dx == r || dy == r);
    pc = !act ? 3'b000 : ((ts && in_brush) || (!ts && on_rim && !blink)) ? cs : BG;
  end
  always_ff @(posedge clk)
    if (clr) begin
      bus.red <= '0;
      bus.green <= '0;
      bus.blue <= '0;
      bus.hsync <= ~SYNC_POL;
      bus.vsync <= ~SYNC_POL;
      bus.active <= 1'b0;
      bus.hcount <= '0;
      bus.vcount <= '0;
      bus.frame_start <= 1'b0;
      xs <= '0;
      ys <= '0;
      cs <= '0;
      ts <= 1'b0;
      ss <= '0;
      bcnt <= '0;
      blink <= 1'b0;
    end else begin
      bus.frame_start <= pix_ce && h == '0 && v == '0;
      if (pix_ce) begin
        bus.red <= CH_W'(ch_expand(pc[2], CH_W));
        bus.green <= CH_W'(ch_expand(pc[1], CH_W));
        bus.blue <= CH_W'(ch_expand(pc[0], CH_W));
        bus.hsync <= hs;
        bus.vsync <= vs;
        bus.active <= act;
        bus.hcount <= h;
        bus.vcount <= v;
      end
      if (bnd) begin
        xs <= bus.x_pos;
        ys <= bus.y_pos;
        cs <= bus.color;
        ts <= bus.tool_on;
        ss <= bus.size_sel;
        bcnt <= bcnt == BW'(BLINK_FRAMES - 1) ? '0 : bcnt + 1'b1;
        if (bcnt == BW'(BLINK_FRAMES - 1)) blink <= ~blink;
      end
    end
endmodule

// File: tb/tb_vga_paint_core.sv
// tb_vga_paint_core: scoreboard bench on a shrunken raster so several frames fit in a short run
module tb_vga_paint_core;
  localparam int DIV = 2, HA = 16, HFP = 2, HS = 3, HBP = 3, VA = 12, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP, VT = VA + VFP + VS + VBP, FRAME = HT * VT * DIV;
  localparam logic [2:0] BG = 3'b001;
  typedef struct packed {
    logic [9:0] h, v;
    logic [2:0] r, g, b;
    logic hs, vs, act, fs;
  } pix_t;
  logic clk = 1'b0, clr = 1'b1;
  int total = 0, bad = 0, cyc = 0, last_cyc = 0;
  bit running = 0, first = 0;
  logic [9:0] ph = '0, pv = '0;
  pix_t q[$];
  pix_t got, want;
  vga_paint_core_if #(.POS_W(10), .CH_W(3), .SIZE_W(2)) bus ();
  vga_paint_core #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0),
    .POS_W(10), .CH_W(3), .SIZE_W(2), .BASE_R(2), .BLINK_FRAMES(3), .BG(BG)
  ) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, g, e);
    end
  endfunction
  // mode 0: nothing drawn, 1: filled rectangle, 2: rectangle border only (bounds may lie off-screen)
  task automatic push_frame(input int mode, input int x0, input int x1, input int y0, input int y1,
                            input logic [2:0] c);
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        pix_t p;
        logic in_r, rim;
        logic [2:0] col;
        in_r = h >= x0 && h <= x1 && v >= y0 && v <= y1;
        rim = in_r && (h == x0 || h == x1 || v == y0 || v == y1);
        p.h = 10'(h);
        p.v = 10'(v);
        p.act = h < HA && v < VA;
        col = !p.act ? 3'b000 : ((mode == 1 && in_r) || (mode == 2 && rim)) ? c : BG;
        p.r = {3{col[2]}};
        p.g = {3{col[1]}};
        p.b = {3{col[0]}};
        p.hs = !(h >= HA + HFP && h < HA + HFP + HS);
        p.vs = !(v >= VA + VFP && v < VA + VFP + VS);
        p.fs = h == 0 && v == 0;
        q.push_back(p);
      end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!clr && (bus.frame_start || bus.hcount != ph || bus.vcount != pv)) begin
      if (!running && bus.frame_start && q.size() > 0) begin
        running = 1;
        first = 1;
      end
      if (running) begin
        if (!first) chk("pixel spacing", 64'(cyc - last_cyc), 64'(DIV));
        first = 0;
        last_cyc = cyc;
        want = q.pop_front();
        got = {bus.hcount, bus.vcount, bus.red, bus.green, bus.blue,
               bus.hsync, bus.vsync, bus.active, bus.frame_start};
        chk($sformatf("pixel h=%0d v=%0d", want.h, want.v), 64'(got), 64'(want));
        if (q.size() == 0) running = 0;
      end
    end
    ph = bus.hcount;
    pv = bus.vcount;
  end
  task automatic set_in(input int x, input int y, input logic [2:0] c, input logic t, input int s);
    bus.x_pos = 10'(x);
    bus.y_pos = 10'(y);
    bus.color = c;
    bus.tool_on = t;
    bus.size_sel = 2'(s);
  endtask
  task automatic wait_fs(output int n);
    n = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus.frame_start) begin
        n = i;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL frame_start timeout: none within %0d clks", 2 * FRAME);
  endtask
  task automatic drain();
    for (int i = 0; i < 8 * FRAME && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected pixels never presented", q.size());
      q.delete();
      running = 0;
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " rgb"}, 64'({bus.red, bus.green, bus.blue}), 64'(0));
    chk({tag, " hsync"}, 64'(bus.hsync), 64'(1));
    chk({tag, " vsync"}, 64'(bus.vsync), 64'(1));
    chk({tag, " active"}, 64'(bus.active), 64'(0));
    chk({tag, " hcount"}, 64'(bus.hcount), 64'(0));
    chk({tag, " vcount"}, 64'(bus.vcount), 64'(0));
    chk({tag, " frame_start"}, 64'(bus.frame_start), 64'(0));
  endtask
  initial begin
    int n;
    bit found;
    set_in(0, 0, 3'b000, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    clr = 1'b0;
    push_frame(2, -2, 2, -2, 2, 3'b000);
    push_frame(1, 1, 9, 0, 8, 3'b100);
    push_frame(2, 10, 14, 4, 8, 3'b010);
    push_frame(0, 0, 0, 0, 0, 3'b000);
    push_frame(1, -8, 8, 3, 19, 3'b011);
    set_in(5, 4, 3'b100, 1'b1, 1);
    wait_fs(n);
    chk("first frame latency", 64'(n), 64'(DIV));
    wait_fs(n);
    repeat (100) @(negedge clk);
    set_in(12, 6, 3'b010, 1'b0, 0);
    wait_fs(n);
    wait_fs(n);
    set_in(0, 11, 3'b011, 1'b1, 2);
    wait_fs(n);
    chk("frame period", 64'(n), 64'(FRAME));
    set_in(30, 0, 3'b111, 1'b1, 3);
    drain();
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      found = bus.hcount == 10'd10 && bus.vcount == 10'd5;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL mid-line point: h=10 v=5 not reached");
    end
    clr = 1'b1;
    @(negedge clk);
    chk_reset("mid-line clr");
    clr = 1'b0;
    push_frame(2, -2, 2, -2, 2, 3'b000);
    push_frame(1, 14, 46, -16, 16, 3'b111);
    wait_fs(n);
    chk("restart latency", 64'(n), 64'(DIV));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_paint_core.md
# vga_paint_core

Parametrised successor to the fixed 640x480 VGA controller of the paint demo. Generates pixel enable, timing counters and syncs from the 100 MHz master clock without a derived clock. Renders a brush cursor whose position, colour, tool state and size are latched once per frame. Sits between the cursor/input logic and the VGA pins in the demo top, replacing the clockdiv display-clock path and the old controller.

## Interface
- DIV, 4: master clocks per pixel (≥1); 100 MHz / 4 = 25 MHz.
- H_ACTIVE, H_FP, H_SYNC, H_BP: 640, 16, 96, 48.
- V_ACTIVE, V_FP, V_SYNC, V_BP: 480, 10, 2, 33.
- SYNC_POL, 0: asserted sync level (0 = active-low).
- POS_W, 10: coordinate width.
- CH_W, 3: bits per colour channel.
- SIZE_W, 2: brush size select width.
- BASE_R, 2: brush half-size at size_sel = 0.
- BLINK_FRAMES, 30: frames per outline blink phase.
- BG, 3'b000: background colour {r,g,b}.
- clk, in, 1: master clock.
- clr, in, 1: reset, synchronous, active-high.
- x_pos, in, POS_W: cursor centre column.
- y_pos, in, POS_W: cursor centre row.
- color, in, 3: brush colour {r,g,b}, one bit per channel.
- tool_on, in, 1: brush down (filled) vs up (outline).
- size_sel, in, SIZE_W: brush size index.
- red, green, blue, out, CH_W each: pixel colour.
- hsync, vsync, out, 1: syncs.
- active, out, 1: displayed pixel is in the visible area.
- hcount, vcount, out, POS_W: coordinates of the displayed pixel.
- frame_start, out, 1: one-clk pulse when pixel (0,0) is presented.

## Operation
- Divider div_cnt counts 0..DIV-1. pix_ce = (div_cnt == DIV-1). With DIV = 1, pix_ce is constant 1.
- On pix_ce, internal h advances and wraps at H_TOTAL-1 to 0. On each h wrap, v advances and wraps at V_TOTAL-1. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Sync is asserted (= SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync follows the same rule on v.
- Shadow latch: on the pix_ce where h = H_TOTAL-1 and v = V_TOTAL-1, x_pos, y_pos, color, tool_on and size_sel are copied into shadows. Input changes mid-frame have no visible effect until the next frame.
- Blink counter: increments at the same boundary. At BLINK_FRAMES-1 it wraps to 0 and toggles blink.
- Brush geometry:
  - r = BASE_R << size_sel, computed at POS_W+SIZE_W bits with no truncation.
  - dx = |h - xs| and dy = |v - ys|, unsigned absolute difference. There is no wrap-around at screen edges; a cursor at column 0 is clipped, not mirrored.
  - inside = dx ≤ r and dy ≤ r.
  - edge = inside and (dx == r or dy == r).
- Pixel colour, in priority order:
  - Not active: 0.
  - tool_on shadow = 1 and inside: brush colour.
  - tool_on shadow = 0, edge and blink = 0: brush colour.
  - Otherwise: BG.
- Colour expansion: each colour bit is replicated CH_W times per channel.
- Reset values: red/green/blue = 0, hsync = vsync = ~SYNC_POL, active = 0, hcount = vcount = 0, frame_start = 0. Internal state: div_cnt, h, v, blink counter and all shadows = 0.
- Before the first frame boundary after reset, shadows are 0: cursor at (0,0), black, outline mode, r = BASE_R.
- clr asserted mid-frame restarts the timing from h = v = 0 on the next clk. No partial-line state survives.

## Timing
- All outputs are registered and updated only on pix_ce, except frame_start.
- Output latency is exactly one pixel period after the counter value. hcount, vcount, active, syncs and RGB describe the same pixel.
- frame_start is high for exactly one clk: the clk in which outputs change to hcount = 0, vcount = 0. It is 0 on all other clks.
- Frame period is H_TOTAL·V_TOTAL·DIV clks: 800·525·4 = 1,680,000 with defaults.

## Structure
- Package vga_pkg holds the default timing constants, the H_TOTAL/V_TOTAL derivation and the colour-expand function.
- Sub-module vga_timing contains div_cnt, h/v counters and raw sync/active generation, and outputs pix_ce, h, v and the boundary strobe.
- Shadow latch, blink counter, brush geometry and the output register stay in the top of vga_paint_core.

## Test plan
- Reset then free-run with defaults:
  - hsync low for 96·4 clks every 3200 clks.
  - vsync low for 2 lines per 525.
  - frame_start spacing 1,680,000 clks.
- Shadow latch: x_pos = 100, y_pos = 50, tool_on = 1, size_sel = 1, color = 3'b100.
  - Next frame: red = 3'b111 exactly for h 96..104, v 46..54; BG elsewhere.
  - Changing x_pos mid-frame does not move the brush until the following frame.
- Outline and blink: tool_on = 0, size_sel = 0.
  - Only perimeter pixels at distance 2 are coloured, in frames 0..29.
  - None are coloured in frames 30..59.
- Edge clip: x_pos = 0, y_pos = 479, size_sel = 3 (r = 16).
  - Coloured area covers h 0..16 and v 463..479.
  - No pixels at h ≥ 624 and none in the blanking interval.
- DIV = 1 and SYNC_POL = 1 build:
  - pix_ce every clk.
  - Syncs active-high.
  - Frame period 420,000 clks.
- clr pulsed mid-line at h = 300:
  - Next clk all outputs equal their reset values.
  - Timing restarts from (0,0) and the shadows are 0.
